// File: rtl/level_pkg.sv
// Shared definitions for the level sequencer: state encoding, per-level
// target codes and default parameter values.
package level_pkg;

  typedef enum logic [2:0] {
    ST_ARMED   = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4,
    ST_WIN     = 3'd5
  } state_t;

  localparam int unsigned DEF_NUM_LEVELS  = 8;
  localparam int unsigned DEF_MAX_TRIES   = 3;
  localparam int unsigned DEF_LOCK_CYCLES = 16;

  // Entry [n] is the code that clears level n.
  localparam logic [7:0][3:0] TARGET = {4'h9, 4'h7, 4'hF, 4'h0,
                                        4'hC, 4'h5, 4'hA, 4'h3};

  function automatic logic [3:0] target_code(input logic [2:0] lvl);
    return TARGET[lvl];
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a level-sensitive switch/button input.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic r_prev;
  logic r_valid;

  // r_valid masks the first sample after reset so an input that is already
  // high when reset releases is not mistaken for a new press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_prev  <= i_d;
      r_valid <= 1'b1;
    end
  end

  assign o_rise = i_d & ~r_prev & r_valid;

endmodule

// File: rtl/level_sequencer.sv
// Code-guessing game controller: steps through levels, counts wrong guesses,
// locks out after too many failures and latches a win at the last level.
module level_sequencer
  import level_pkg::*;
#(
  parameter int unsigned NUM_LEVELS  = DEF_NUM_LEVELS,
  parameter int unsigned MAX_TRIES   = DEF_MAX_TRIES,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] data,
  input  logic       submit,
  input  logic       nextLevel,
  output logic [2:0] out,
  output logic [1:0] tries,
  output logic       pass,
  output logic       fail,
  output logic       locked,
  output logic       win
);

  localparam int unsigned LW = $clog2(LOCK_CYCLES + 1);
  localparam logic [2:0]    LAST_LVL  = 3'(NUM_LEVELS - 1);
  localparam logic [1:0]    TRY_LIMIT = 2'(MAX_TRIES);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_CYCLES - 1);

  state_t        r_state;
  logic [2:0]    r_out;
  logic [1:0]    r_tries;
  logic [3:0]    r_data;
  logic [LW-1:0] r_lock_cnt;

  logic       w_sub_rise;
  logic       w_nl_rise;
  logic [1:0] w_tries_inc;

  edge_detect u_submit_edge (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (submit),
    .o_rise (w_sub_rise)
  );

  edge_detect u_next_edge (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (nextLevel),
    .o_rise (w_nl_rise)
  );

  assign w_tries_inc = r_tries + 2'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_ARMED;
      r_out      <= '0;
      r_tries    <= '0;
      r_data     <= '0;
      r_lock_cnt <= '0;
    end else begin
      case (r_state)
        ST_ARMED, ST_FAIL: begin
          if (w_sub_rise) begin
            r_data  <= data;
            r_state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (r_data == target_code(r_out)) begin
            r_state <= ST_PASS;
          end else begin
            r_tries <= w_tries_inc;
            if (w_tries_inc == TRY_LIMIT) begin
              r_lock_cnt <= '0;
              r_state    <= ST_LOCKOUT;
            end else begin
              r_state <= ST_FAIL;
            end
          end
        end
        ST_PASS: begin
          if (w_nl_rise) begin
            if (r_out == LAST_LVL) begin
              r_state <= ST_WIN;
            end else begin
              r_out   <= r_out + 3'd1;
              r_tries <= '0;
              r_state <= ST_ARMED;
            end
          end
        end
        ST_LOCKOUT: begin
          // Counter runs 0..LOCK_CYCLES-1, so the state lasts exactly LOCK_CYCLES clocks.
          if (r_lock_cnt == LOCK_LAST) begin
            r_lock_cnt <= '0;
            r_out      <= '0;
            r_tries    <= '0;
            r_state    <= ST_ARMED;
          end else begin
            r_lock_cnt <= r_lock_cnt + 1'b1;
          end
        end
        ST_WIN: begin
          r_state <= ST_WIN;
        end
        default: begin
          r_state <= ST_ARMED;
        end
      endcase
    end
  end

  assign out    = r_out;
  assign tries  = r_tries;
  assign pass   = (r_state == ST_PASS);
  assign fail   = (r_state == ST_FAIL);
  assign locked = (r_state == ST_LOCKOUT);
  assign win    = (r_state == ST_WIN);

endmodule
